// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared constants and helpers for the serial deserializer
// Purpose: bit-counter width derivation, output-buffer state encoding and the
//          shift-direction helper used to insert one serial bit into a word.
package deser_pkg;

  localparam logic BUF_EMPTY = 1'b0;
  localparam logic BUF_FULL  = 1'b1;

  // Counter must hold 0..WIDTH-1 and still be at least one bit wide for WIDTH=1.
  function automatic int cw_of(input int width);
    return $clog2(width) + 1;
  endfunction

  // Inserts one bit into a word of 'width' bits held in the low bits of 'sr'.
  // MSB-first: shift left, bit enters at bit 0. LSB-first: shift right, bit
  // enters at bit width-1. Bits above 'width' are don't-care for the caller.
  function automatic logic [31:0] shift_in(input logic [31:0] sr, input logic din,
                                           input int width, input bit msb_first);
    if (msb_first) return (sr << 1) | 32'(din);
    else           return (sr >> 1) | (32'(din) << (width - 1));
  endfunction

endpackage

// File: rtl/deser_hold_buf.sv
// rtl/deser_hold_buf.sv - one-entry output buffer with valid/ready release and overrun flag
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load/i_data completed
//        word offered this edge; i_ready consumer ready; i_clr_ovr clears overrun;
//        o_data/o_valid buffered word; o_overrun sticky drop flag.
module deser_hold_buf
  import deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  input  logic             i_clr_ovr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic             r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_ovr;
  logic             w_hs;
  logic             w_drop;

  assign w_hs   = (r_state == BUF_FULL) && i_ready;
  // A word arriving while full is only lost when the consumer is not
  // freeing the slot on the same edge.
  assign w_drop = i_load && (r_state == BUF_FULL) && !i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= BUF_EMPTY;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (i_load && !w_drop) begin
        r_data  <= i_data;
        r_state <= BUF_FULL;
      end else if (w_hs) begin
        r_state <= BUF_EMPTY;
      end
      // Set has priority over clear.
      if (w_drop)         r_ovr <= 1'b1;
      else if (i_clr_ovr) r_ovr <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = (r_state == BUF_FULL);
  assign o_overrun = r_ovr;

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - serial-to-parallel word assembler with held output
// Ports: Clk, _Reset (async active-low); Din/Din_Valid serial bit and strobe;
//        Sync discards partial word; Word/Word_Valid/Word_Ready output handshake;
//        Overrun/Clr_Ovr sticky drop flag and its clear; Bit_Count partial bits held.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = cw_of(WIDTH)
) (
  input  logic             Clk,
  input  logic             _Reset,
  input  logic             Din,
  input  logic             Din_Valid,
  input  logic             Sync,
  output logic [WIDTH-1:0] Word,
  output logic             Word_Valid,
  input  logic             Word_Ready,
  output logic             Overrun,
  input  logic             Clr_Ovr,
  output logic [CW-1:0]    Bit_Count
);

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_base_sr;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    w_base_cnt;
  logic             w_complete;

  // Sync throws away the partial word first, so a bit accepted on the same
  // edge becomes bit one of a fresh word.
  assign w_base_sr  = Sync ? '0 : r_sr;
  assign w_base_cnt = Sync ? '0 : r_cnt;
  assign w_shifted  = WIDTH'(shift_in(32'(w_base_sr), Din, WIDTH, MSB_FIRST));
  assign w_complete = Din_Valid && (w_base_cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge _Reset) begin
    if (!_Reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (Din_Valid) begin
      r_sr  <= w_complete ? '0 : w_shifted;
      r_cnt <= w_complete ? '0 : w_base_cnt + CW'(1);
    end else if (Sync) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end
  end

  deser_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .i_clk     (Clk),
    .i_rst_n   (_Reset),
    .i_load    (w_complete),
    .i_data    (w_shifted),
    .i_ready   (Word_Ready),
    .i_clr_ovr (Clr_Ovr),
    .o_data    (Word),
    .o_valid   (Word_Valid),
    .o_overrun (Overrun)
  );

  assign Bit_Count = r_cnt;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - self-checking bench for serial_deserializer
module tb_serial_deserializer;

  logic Clk = 1'b0;
  logic _Reset = 1'b0;
  logic Din = 1'b0, Din_Valid = 1'b0, Sync = 1'b0, Word_Ready = 1'b0, Clr_Ovr = 1'b0;

  logic [7:0] m_word, l_word;
  logic [0:0] o_word;
  logic       m_valid, l_valid, o_valid;
  logic       m_ovr, l_ovr, o_ovr;
  logic [3:0] m_cnt, l_cnt;
  logic [0:0] o_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk(Clk), ._Reset(_Reset), .Din(Din), .Din_Valid(Din_Valid), .Sync(Sync),
    .Word(m_word), .Word_Valid(m_valid), .Word_Ready(Word_Ready),
    .Overrun(m_ovr), .Clr_Ovr(Clr_Ovr), .Bit_Count(m_cnt));

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(Clk), ._Reset(_Reset), .Din(Din), .Din_Valid(Din_Valid), .Sync(Sync),
    .Word(l_word), .Word_Valid(l_valid), .Word_Ready(Word_Ready),
    .Overrun(l_ovr), .Clr_Ovr(Clr_Ovr), .Bit_Count(l_cnt));

  serial_deserializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_one (
    .Clk(Clk), ._Reset(_Reset), .Din(Din), .Din_Valid(Din_Valid), .Sync(Sync),
    .Word(o_word), .Word_Valid(o_valid), .Word_Ready(Word_Ready),
    .Overrun(o_ovr), .Clr_Ovr(Clr_Ovr), .Bit_Count(o_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: instance 0 = 8-bit MSB-first, 1 = 8-bit LSB-first, 2 = 1-bit.
  // Bits are recorded by arrival order and mapped to word positions at completion.
  function automatic int wid(input int k);
    return (k == 2) ? 1 : 8;
  endfunction
  function automatic bit msbf(input int k);
    return (k != 1);
  endfunction

  int          mcnt  [3] = '{default: 0};
  logic [31:0] mbits [3] = '{default: 0};
  logic        mvalid[3] = '{default: 0};
  logic [31:0] mword [3] = '{default: 0};
  logic        movr  [3] = '{default: 0};
  logic [31:0] t_w;
  bit          t_done, t_hs, t_drop;

  always @(posedge Clk or negedge _Reset) begin
    if (!_Reset) begin
      for (int k = 0; k < 3; k++) begin
        mcnt[k] = 0; mbits[k] = 0; mvalid[k] = 0; mword[k] = 0; movr[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        t_done = 0; t_drop = 0; t_w = 0;
        if (Sync) mcnt[k] = 0;
        if (Din_Valid) begin
          mbits[k][mcnt[k]] = Din;
          mcnt[k]++;
          if (mcnt[k] == wid(k)) begin
            for (int i = 0; i < wid(k); i++)
              if (msbf(k)) t_w[wid(k)-1-i] = mbits[k][i];
              else         t_w[i]          = mbits[k][i];
            mcnt[k] = 0;
            t_done  = 1;
          end
        end
        t_hs = mvalid[k] && Word_Ready;
        if (t_done) begin
          if (!mvalid[k] || t_hs) begin mword[k] = t_w; mvalid[k] = 1; end
          else t_drop = 1;
        end else if (t_hs) mvalid[k] = 0;
        if (t_drop) movr[k] = 1;
        else if (Clr_Ovr) movr[k] = 0;
      end
    end
  end

  always @(negedge Clk) begin
    chk("msb_word",  32'(m_word),  mword[0]);
    chk("msb_valid", 32'(m_valid), 32'(mvalid[0]));
    chk("msb_ovr",   32'(m_ovr),   32'(movr[0]));
    chk("msb_cnt",   32'(m_cnt),   32'(mcnt[0]));
    chk("lsb_word",  32'(l_word),  mword[1]);
    chk("lsb_valid", 32'(l_valid), 32'(mvalid[1]));
    chk("lsb_ovr",   32'(l_ovr),   32'(movr[1]));
    chk("lsb_cnt",   32'(l_cnt),   32'(mcnt[1]));
    chk("w1_word",   32'(o_word),  mword[2]);
    chk("w1_valid",  32'(o_valid), 32'(mvalid[2]));
    chk("w1_ovr",    32'(o_ovr),   32'(movr[2]));
    chk("w1_cnt",    32'(o_cnt),   32'(mcnt[2]));
  end

  task automatic step(input logic v, input logic d, input logic s, input logic r, input logic c);
    Din_Valid = v; Din = d; Sync = s; Word_Ready = r; Clr_Ovr = c;
    @(posedge Clk);
    #2;
  endtask

  // Sends b[7] first; Word_Ready is r_rest for the first seven bits, r_last for the eighth.
  task automatic send_byte(input logic [7:0] b, input logic r_last, input logic r_rest);
    for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0, (i == 0) ? r_last : r_rest, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #2;
    chk("rst_word",  32'(m_word),  32'h0);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_ovr",   32'(m_ovr),   32'h0);
    chk("rst_cnt",   32'(m_cnt),   32'h0);
    _Reset = 1'b1;

    // Basic word, both bit orders
    send_byte(8'hA5, 1'b1, 1'b1);
    chk("basic_valid", 32'(m_valid), 32'h1);
    chk("basic_msb",   32'(m_word),  32'hA5);
    chk("basic_lsb",   32'(l_word),  32'hA5);
    chk("basic_ovr",   32'(m_ovr),   32'h0);
    chk("basic_w1",    32'(o_word),  32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_drain", 32'(m_valid), 32'h0);

    send_byte(8'h80, 1'b1, 1'b1);
    chk("lsb_01",  32'(l_word), 32'h01);
    chk("msb_80",  32'(m_word), 32'h80);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure and overrun
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    chk("ovr_word",  32'(m_word),  32'h3C);
    chk("ovr_set",   32'(m_ovr),   32'h1);
    chk("ovr_valid", 32'(m_valid), 32'h1);
    chk("ovr_lsb",   32'(l_word),  32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_drain", 32'(m_valid), 32'h0);
    chk("ovr_stick", 32'(m_ovr),   32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr",   32'(m_ovr),   32'h0);

    // Handshake on the same edge as a completing word
    send_byte(8'h11, 1'b0, 1'b0);
    chk("same_11", 32'(m_word), 32'h11);
    send_byte(8'h22, 1'b1, 1'b0);
    chk("same_22",    32'(m_word),  32'h22);
    chk("same_valid", 32'(m_valid), 32'h1);
    chk("same_ovr",   32'(m_ovr),   32'h0);

    // Sync resynchronisation
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sync_cnt1", 32'(m_cnt), 32'h1);
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sync_word", 32'(m_word),  32'h80);
    chk("sync_vld",  32'(m_valid), 32'h1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sync_cnt3", 32'(m_cnt), 32'h3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sync_cnt0", 32'(m_cnt),   32'h0);
    chk("sync_hold", 32'(m_valid), 32'h1);
    chk("sync_keep", 32'(m_word),  32'h80);

    // Asynchronous reset mid-word with buffer full and overrun set
    send_byte(8'hFF, 1'b0, 1'b0);
    chk("pre_ovr", 32'(m_ovr), 32'h1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 _Reset = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'h0);
    chk("arst_word",  32'(m_word),  32'h0);
    chk("arst_ovr",   32'(m_ovr),   32'h0);
    chk("arst_cnt",   32'(m_cnt),   32'h0);
    #2 _Reset = 1'b1;
    repeat (7) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("arst_7bits", 32'(m_valid), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("arst_8bits", 32'(m_valid), 32'h1);
    chk("arst_ff",    32'(m_word),  32'hFF);

    // Randomised traffic checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 15) == 0),
           1'($urandom), ($urandom_range(0, 19) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
